// File: rtl/hazard_scoreboard_pkg.sv
// Shared stage encodings and scoreboard entry layout for the D-stage hazard unit.
package hazard_scoreboard_pkg;

  localparam logic [1:0] STAGE_DECODE  = 2'd0;
  localparam logic [1:0] STAGE_EXECUTE = 2'd1;
  localparam logic [1:0] STAGE_MEM     = 2'd2;
  localparam logic [1:0] STAGE_MAX     = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [4:0] waddr;
    logic [1:0] wstage;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

  // Cycles until the writer sitting in stage k has its result; 0 means forwardable now.
  function automatic int tnew(sb_entry_t e, int k);
    return (int'(e.wstage) >= k) ? int'(e.wstage) - k + 1 : 0;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request/response bundle between decode (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 32
);
  logic                     d_valid;
  logic [NUM_SRC*5-1:0]     d_read_addr;
  logic [NUM_SRC*2-1:0]     d_read_stage;
  logic [4:0]               d_write_addr;
  logic [1:0]               d_write_stage;
  logic                     d_mdu_use;
  logic                     mdu_busy;
  logic                     flush;
  logic                     stall;
  logic                     bubble;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output d_valid, d_read_addr, d_read_stage, d_write_addr, d_write_stage,
           d_mdu_use, mdu_busy, flush,
    input  stall, bubble, fwd_sel, stall_count
  );

  modport slave (
    input  d_valid, d_read_addr, d_read_stage, d_write_addr, d_write_stage,
           d_mdu_use, mdu_busy, flush,
    output stall, bubble, fwd_sel, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard_port_check.sv
// One GRF source port checked against every in-flight writer: youngest match wins.
module hazard_port_check
  import hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 2
) (
  input  logic [4:0]                 raddr,
  input  logic [1:0]                 rstage,
  input  sb_entry_t [PIPE_DEPTH:1]   entries,
  output logic                       port_stall,
  output logic [SEL_W-1:0]           fwd_sel
);

  logic found;
  int   tn;

  always_comb begin
    found      = 1'b0;
    tn         = 0;
    port_stall = 1'b0;
    fwd_sel    = '0;
    if (rstage != STAGE_MAX && raddr != 5'd0) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        // The first hit shadows older writers of the same register.
        if (!found && entries[k].valid && entries[k].waddr == raddr) begin
          found = 1'b1;
          tn    = tnew(entries[k], k);
          if (tn > int'(rstage) - int'(STAGE_DECODE)) port_stall = 1'b1;
          if (tn == 0) fwd_sel = SEL_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller beside decode: shift-register scoreboard of GRF writers,
// MDU interlock, flush priority and a saturating stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  hazard_scoreboard_if.slave sb
);

  sb_entry_t [PIPE_DEPTH:1]   entries_q, entries_d;
  logic [CNT_W-1:0]           stall_count_q, stall_count_d;
  logic [NUM_SRC-1:0]         port_stall;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel_w;
  logic                       mdu_stall;
  logic                       stall_w;

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    hazard_port_check #(.PIPE_DEPTH(PIPE_DEPTH), .SEL_W(SEL_W)) u_chk (
      .raddr      (sb.d_read_addr[5*p +: 5]),
      .rstage     (sb.d_read_stage[2*p +: 2]),
      .entries    (entries_q),
      .port_stall (port_stall[p]),
      .fwd_sel    (fwd_sel_w[SEL_W*p +: SEL_W])
    );
  end

  always_comb begin
    mdu_stall = sb.d_valid && sb.d_mdu_use && sb.mdu_busy;
    stall_w   = sb.d_valid && !sb.flush && ((|port_stall) || mdu_stall);

    // A stalled or flushed D instruction leaves a bubble in E.
    entries_d[1] = '0;
    if (sb.d_valid && !stall_w && !sb.flush && sb.d_write_addr != 5'd0)
      entries_d[1] = '{valid: 1'b1, waddr: sb.d_write_addr, wstage: sb.d_write_stage};
    for (int k = 2; k <= PIPE_DEPTH; k++) entries_d[k] = entries_q[k-1];

    stall_count_d = stall_count_q;
    if (stall_w && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q     <= '0;
      stall_count_q <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign sb.stall       = stall_w;
  assign sb.bubble      = stall_w || sb.flush;
  assign sb.fwd_sel     = fwd_sel_w;
  assign sb.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: pipeline hazard scenarios plus a narrow-counter copy.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  hazard_scoreboard_if #(.NUM_SRC(2), .SEL_W(2), .CNT_W(32)) sb ();
  hazard_scoreboard_if #(.NUM_SRC(2), .SEL_W(2), .CNT_W(3))  sb3 ();

  hazard_scoreboard #(.NUM_SRC(2), .PIPE_DEPTH(3), .SEL_W(2), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .sb(sb.slave)
  );

  hazard_scoreboard #(.NUM_SRC(2), .PIPE_DEPTH(3), .SEL_W(2), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .sb(sb3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [4:0] ra0, input logic [1:0] rs0,
                       input logic [4:0] ra1, input logic [1:0] rs1,
                       input logic [4:0] wa, input logic [1:0] ws, input logic mu);
    sb.d_valid       = v;
    sb.d_read_addr   = {ra1, ra0};
    sb.d_read_stage  = {rs1, rs0};
    sb.d_write_addr  = wa;
    sb.d_write_stage = ws;
    sb.d_mdu_use     = mu;
  endtask

  task automatic idle();
    set_d(1'b0, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    sb.mdu_busy = 1'b0;
    sb.flush    = 1'b0;
    sb3.d_valid = 1'b0; sb3.d_read_addr = '0; sb3.d_read_stage = '1;
    sb3.d_write_addr = '0; sb3.d_write_stage = '0; sb3.d_mdu_use = 1'b0;
    sb3.mdu_busy = 1'b0; sb3.flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    set_d(1'b1, 5'd8, STAGE_DECODE, 5'd9, STAGE_DECODE, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.bubble !== 1'b0) $display("FAIL reset_bubble got %b exp 0", sb.bubble); else pass_cnt++;
    total_cnt++; if (sb.fwd_sel !== 4'h0) $display("FAIL reset_fwd got %h exp 0", sb.fwd_sel); else pass_cnt++;
    total_cnt++; if (sb.stall_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", sb.stall_count); else pass_cnt++;
  endtask

  // lw $8 then addu $10,$8 reading at EXECUTE: one load-use stall
  task automatic test_load_use();
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd8, STAGE_MEM, 1'b0);
    tick();
    set_d(1'b1, 5'd8, STAGE_EXECUTE, 5'd0, STAGE_MAX, 5'd10, STAGE_EXECUTE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.bubble !== 1'b1) $display("FAIL lu_bubble got %b exp 1", sb.bubble); else pass_cnt++;
    tick();
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL lu_stall2 got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.fwd_sel !== 4'h0) $display("FAIL lu_fwd got %h exp 0", sb.fwd_sel); else pass_cnt++;
    total_cnt++; if (sb.stall_count !== 32'd1) $display("FAIL lu_count got %0d exp 1", sb.stall_count); else pass_cnt++;
    // addu issues now; the stalled copy must not have been recorded, so a reader sees it only in E
    tick();
    set_d(1'b1, 5'd10, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b1) $display("FAIL lu_addu_e got %b exp 1", sb.stall); else pass_cnt++;
  endtask

  // addu $9 in E, beq reads $9 at DECODE
  task automatic test_alu_branch();
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd9, STAGE_EXECUTE, 1'b0);
    tick();
    set_d(1'b1, 5'd9, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b1) $display("FAIL br_stall got %b exp 1", sb.stall); else pass_cnt++;
    tick();
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL br_stall2 got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.fwd_sel !== 4'h2) $display("FAIL br_fwd got %h exp 2", sb.fwd_sel); else pass_cnt++;
  endtask

  // jal in E writes $31 at DECODE; jr $31 on both ports forwards from E
  task automatic test_jal_jr();
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd31, STAGE_DECODE, 1'b0);
    tick();
    set_d(1'b1, 5'd31, STAGE_DECODE, 5'd31, STAGE_DECODE, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL jr_stall got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.fwd_sel !== 4'h5) $display("FAIL jr_fwd got %h exp 5", sb.fwd_sel); else pass_cnt++;
  endtask

  // ori $5 in M (ready) shadowed by lw $5 in E
  task automatic test_shadow();
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd5, STAGE_EXECUTE, 1'b0);
    tick();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd5, STAGE_MEM, 1'b0);
    tick();
    set_d(1'b1, 5'd5, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b1) $display("FAIL sh_stall1 got %b exp 1", sb.stall); else pass_cnt++;
    tick();
    total_cnt++; if (sb.stall !== 1'b1) $display("FAIL sh_stall2 got %b exp 1", sb.stall); else pass_cnt++;
    tick();
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL sh_stall3 got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.fwd_sel !== 4'h3) $display("FAIL sh_fwd got %h exp 3", sb.fwd_sel); else pass_cnt++;
    total_cnt++; if (sb.stall_count !== 32'd2) $display("FAIL sh_count got %0d exp 2", sb.stall_count); else pass_cnt++;
  endtask

  // $0 sources, unused ports and zero-destination producers never interlock
  task automatic test_ignored();
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_MEM, 1'b0);
    tick();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd7, STAGE_MEM, 1'b0);
    tick();
    set_d(1'b1, 5'd0, STAGE_DECODE, 5'd7, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL ign_stall got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.fwd_sel !== 4'h0) $display("FAIL ign_fwd got %h exp 0", sb.fwd_sel); else pass_cnt++;
    set_d(1'b1, 5'd0, STAGE_DECODE, 5'd7, STAGE_DECODE, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b1) $display("FAIL ign_port1 got %b exp 1", sb.stall); else pass_cnt++;
    // a flushed writer is not recorded either
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd6, STAGE_MEM, 1'b0);
    sb.flush = 1'b1;
    tick();
    sb.flush = 1'b0;
    set_d(1'b1, 5'd6, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL flush_rec got %b exp 0", sb.stall); else pass_cnt++;
  endtask

  task automatic test_mdu();
    do_reset();
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b1);
    sb.mdu_busy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      total_cnt++; if (sb.stall !== 1'b1) $display("FAIL mdu_stall c%0d got %b exp 1", c, sb.stall); else pass_cnt++;
      tick();
    end
    sb.mdu_busy = 1'b0;
    #1;
    total_cnt++; if (sb.stall_count !== 32'd4) $display("FAIL mdu_count got %0d exp 4", sb.stall_count); else pass_cnt++;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL mdu_free got %b exp 0", sb.stall); else pass_cnt++;
    // busy again: stall, then flush, then reset while a writer sits in D
    sb.mdu_busy = 1'b1;
    tick();
    sb.flush = 1'b1;
    #1;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL fl_stall got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.bubble !== 1'b1) $display("FAIL fl_bubble got %b exp 1", sb.bubble); else pass_cnt++;
    tick();
    sb.flush = 1'b0;
    sb.mdu_busy = 1'b0;
    set_d(1'b1, 5'd0, STAGE_MAX, 5'd0, STAGE_MAX, 5'd4, STAGE_MEM, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_d(1'b1, 5'd4, STAGE_DECODE, 5'd0, STAGE_MAX, 5'd0, STAGE_DECODE, 1'b0);
    #1;
    total_cnt++; if (sb.stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", sb.stall); else pass_cnt++;
    total_cnt++; if (sb.stall_count !== 32'd0) $display("FAIL rst_count got %0d exp 0", sb.stall_count); else pass_cnt++;
  endtask

  // 3-bit counter copy: 9 stall cycles must stop at 7
  task automatic test_saturate();
    do_reset();
    sb3.d_valid = 1'b1; sb3.d_mdu_use = 1'b1; sb3.mdu_busy = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    total_cnt++; if (sb3.stall_count !== 3'd7) $display("FAIL sat_full got %0d exp 7", sb3.stall_count); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (sb3.stall_count !== 3'd7) $display("FAIL sat_hold got %0d exp 7", sb3.stall_count); else pass_cnt++;
    total_cnt++; if (sb3.stall !== 1'b1) $display("FAIL sat_stall got %b exp 1", sb3.stall); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_alu_branch();
    test_jal_jr();
    test_shadow();
    test_ignored();
    test_mdu();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
